bar_frame_processor: RTL and testbench
======================================

# bar_frame_processor

Frame-synchronised bar processor between the microphone sampler and the VGA bar renderer. On each accepted rising edge of `vsync` it snapshots all channel samples and processes them one channel per cycle in a selectable mode: raw, magnitude, or peak-hold with exponential decay. It then publishes the new bar heights atomically, so the renderer never sees a half-updated frame. It replaces the fixed 16×18 latch in the top level with a parametrised, tear-free, overrun-reporting block.

## Interface
- `NUM_BARS`, default 16: channel count; must be ≥ 2.
- `SAMPLE_W`, default 18: sample and bar width in bits.
- `DECAY_SHIFT`, default 3: peak-hold decay shift; legal range 1..SAMPLE_W-1.
- `clk` input, 1 bit: single clock (25 MHz pixel clock domain).
- `rst` input, 1 bit: synchronous, active-high reset.
- `vsync` input, 1 bit: frame sync level from the VGA timing block, synchronous to `clk`.
- `freeze` input, 1 bit: when high at an accepted edge, that frame is skipped and bars hold.
- `mode` input, 2 bits: processing mode. 0 = raw, 1 = magnitude, 2 = peak-hold, 3 = treated as 0.
- `samples` input, NUM_BARS*SAMPLE_W bits: channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]; signed two's complement.
- `bars` output, NUM_BARS*SAMPLE_W bits: published bar heights, same packing as `samples`.
- `frame_done` output, 1 bit: one-cycle pulse on the cycle `bars` first shows a new frame.
- `busy` output, 1 bit: high while in CAPTURE or UPDATE.
- `overrun` output, 1 bit: sticky flag, set when a `vsync` rising edge arrives while `busy` is high; cleared only by `rst`.

## Operation
- Edge detect: `vsync_q` registers `vsync`. A rise is `vsync & ~vsync_q`.
- States: IDLE, CAPTURE, UPDATE.
- IDLE:
  - On a rise with `freeze` = 0, go to CAPTURE.
  - On a rise with `freeze` = 1, stay in IDLE; no other effect.
- CAPTURE (1 cycle):
  - Copy `samples` into the shadow buffer.
  - Latch `mode`.
  - Clear the channel index to 0.
  - Go to UPDATE.
- UPDATE (NUM_BARS cycles): compute channel `idx` into the work bank, then increment `idx`. Per latched mode:
  - raw: work[idx] = shadow[idx] bits, unchanged.
  - magnitude: work[idx] = |shadow[idx]|. The most negative value saturates to 2^(SAMPLE_W-1)-1.
  - peak-hold:
    - d = work[idx] - (work[idx] >> DECAY_SHIFT).
    - If work[idx] ≠ 0 and the shift term is 0, then d = work[idx] - 1.
    - work[idx] = max(|shadow[idx]|, d), unsigned compare.
- UPDATE exit: at `idx` = NUM_BARS-1, the same edge copies the work bank (including the final channel) to `bars`, pulses `frame_done`, and returns to IDLE.
- The work bank persists across frames; peak-hold depends on this.
- Mode changes take effect only at the next CAPTURE.
- A rise while `busy` is high is dropped and sets `overrun`. Processing of the current frame continues unaffected.
- `samples` may change freely outside the CAPTURE sampling edge.

## Timing
- Reset values: state IDLE, `vsync_q` = 1 (no spurious edge if `vsync` is high at reset release), `idx` 0, shadow/work/`bars` all 0, `frame_done` 0, `busy` 0, `overrun` 0.
- Let E0 be the first edge where `vsync` = 1 and `vsync_q` = 0.
  - E0: state becomes CAPTURE.
  - E1: `samples` sampled into shadow.
  - E2..E(NUM_BARS+1): channels 0..NUM_BARS-1 processed.
  - E(NUM_BARS+1): `bars` updated and `frame_done` = 1 for exactly one cycle.
  - Latency from E0 to new `bars`: NUM_BARS+1 cycles.
- `busy` is high from after E0 through E(NUM_BARS+1); it is low in the cycle `frame_done` is high.
- A rise at the same edge the block returns to IDLE is an overrun: the state was still UPDATE when the rise was sampled.
- `bars` changes only on `frame_done` edges or on `rst`. There are no partial updates.
- Reset mid-frame: abort at the next edge, clear all state, and produce no `frame_done`.

## Test plan
- **Raw capture.** NUM_BARS=4, SAMPLE_W=8, mode 0, samples {0x7F, 0x80, 0x01, 0x00} (ch0..3), one `vsync` rise at E0.
  - `bars` = {0x7F, 0x80, 0x01, 0x00} at E5.
  - `frame_done` high for that one cycle only.
  - `bars` = 0 before E5.
- **Magnitude.** Mode 1, samples {0x80, 0xFF, 0x05, 0xFB}.
  - `bars` = {0x7F, 0x01, 0x05, 0x05}.
- **Peak-hold decay.** Mode 2, DECAY_SHIFT=3.
  - Frame 1, ch0 = 0x40 → bar 0x40.
  - Frames 2 and 3, ch0 = 0 → 0x38, then 0x31.
  - Bar 0x03 with input 0 decays to 0x02.
  - Input 0x50 against bar 0x31 → 0x50.
- **Overrun and freeze.**
  - Second rise at E3 → `overrun` = 1 and stays 1; the frame still completes at E5 with the first snapshot.
  - A rise with `freeze` = 1 → no `busy`, no `frame_done`, `bars` unchanged.
- **Reset.**
  - `rst` at E3 mid-UPDATE → at the next edge all outputs are 0, state IDLE, no `frame_done`.
  - `vsync` held high through reset release → no frame starts until `vsync` falls and rises again.

Source files
------------

// File: rtl/bar_frame_processor.sv
// Frame-synchronised bar processor: snapshots all channels on a vsync rise and processes one channel per cycle (raw/magnitude/peak-hold).
// Latency: NUM_BARS+1 cycles from the accepted vsync rise to the atomic bars update; frame_done pulses on that edge.
// No backpressure: a vsync rise while busy is dropped and sets the sticky overrun flag.
module bar_frame_processor #(
    parameter int NUM_BARS    = 16,
    parameter int SAMPLE_W    = 18,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vsync,
    input  logic                         freeze,
    input  logic [1:0]                   mode,
    input  logic [NUM_BARS*SAMPLE_W-1:0] samples,
    output logic [NUM_BARS*SAMPLE_W-1:0] bars,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W = $clog2(NUM_BARS);
    localparam logic [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_UPDATE
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          mode_q;
    logic                frame_done_q;
    logic                overrun_q;
    logic [SAMPLE_W-1:0] shadow_q [NUM_BARS];
    logic [SAMPLE_W-1:0] work_q   [NUM_BARS];
    logic [SAMPLE_W-1:0] bars_q   [NUM_BARS];

    logic                rise;
    logic                last_ch;
    logic [SAMPLE_W-1:0] smp, cur, mag, shr, decayed, new_val;

    assign rise    = vsync & ~vsync_q;
    assign last_ch = (idx_q == IDX_W'(NUM_BARS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rise && !freeze) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_UPDATE;
            ST_UPDATE:  if (last_ch) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Per-channel datapath for the channel currently addressed by idx_q.
    always_comb begin
        smp = shadow_q[idx_q];
        cur = work_q[idx_q];
        if (!smp[SAMPLE_W-1])   mag = smp;
        else if (smp == MIN_NEG) mag = MAX_POS;
        else                     mag = -smp;
        shr = cur >> DECAY_SHIFT;
        // Small bars would otherwise never decay once the shift term reaches zero.
        if (cur != '0 && shr == '0) decayed = cur - SAMPLE_W'(1);
        else                        decayed = cur - shr;
        case (mode_q)
            2'd1:    new_val = mag;
            2'd2:    new_val = (mag > decayed) ? mag : decayed;
            default: new_val = smp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q      <= 1'b1;
            idx_q        <= '0;
            mode_q       <= 2'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < NUM_BARS; k++) begin
                shadow_q[k] <= '0;
                work_q[k]   <= '0;
                bars_q[k]   <= '0;
            end
        end else begin
            vsync_q      <= vsync;
            frame_done_q <= 1'b0;
            if (rise && state_q != ST_IDLE) overrun_q <= 1'b1;
            case (state_q)
                ST_CAPTURE: begin
                    for (int k = 0; k < NUM_BARS; k++)
                        shadow_q[k] <= samples[k*SAMPLE_W +: SAMPLE_W];
                    mode_q <= mode;
                    idx_q  <= '0;
                end
                ST_UPDATE: begin
                    work_q[idx_q] <= new_val;
                    if (last_ch) begin
                        idx_q        <= '0;
                        frame_done_q <= 1'b1;
                        // Publish the whole bank at once, folding in the channel computed this cycle.
                        for (int k = 0; k < NUM_BARS; k++)
                            bars_q[k] <= (IDX_W'(k) == idx_q) ? new_val : work_q[k];
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bars
        assign bars[g*SAMPLE_W +: SAMPLE_W] = bars_q[g];
    end

    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bar_frame_processor.sv
// Directed bench for bar_frame_processor with 4 channels of 8 bits and decay shift 3.
module tb_bar_frame_processor;

    localparam int NB = 4;
    localparam int SW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              vsync;
    logic              freeze;
    logic [1:0]        mode;
    logic [NB*SW-1:0]  samples;
    logic [NB*SW-1:0]  bars;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    logic fd_seen, busy_seen;

    bar_frame_processor #(.NUM_BARS(NB), .SAMPLE_W(SW), .DECAY_SHIFT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .freeze     (freeze),
        .mode       (mode),
        .samples    (samples),
        .bars       (bars),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one accepted rise and runs through E5; caller inspects the E5 outputs.
    task automatic run_frame(input logic [1:0] m, input logic [31:0] s);
        mode    = m;
        samples = s;
        vsync   = 1'b1;
        tick();
        vsync   = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; freeze = 1'b0; mode = 2'd0; samples = '0;
        repeat (2) tick();
        check("rst_bars", bars, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_fd", {31'b0, frame_done}, 32'h0);
        check("rst_ovr", {31'b0, overrun}, 32'h0);
        rst = 1'b0;
        tick();

        // Raw capture; mode/samples changed after the snapshot must not matter.
        samples = 32'h0001807F; mode = 2'd0; vsync = 1'b1;
        tick();
        check("raw_busy_e0", {31'b0, busy}, 32'h1);
        vsync = 1'b0;
        tick();
        samples = 32'hDEADBEEF; mode = 2'd1;
        repeat (3) tick();
        check("raw_bars_e4", bars, 32'h0);
        check("raw_fd_e4", {31'b0, frame_done}, 32'h0);
        tick();
        check("raw_bars_e5", bars, 32'h0001807F);
        check("raw_fd_e5", {31'b0, frame_done}, 32'h1);
        check("raw_busy_e5", {31'b0, busy}, 32'h0);
        tick();
        check("raw_fd_e6", {31'b0, frame_done}, 32'h0);
        check("raw_bars_e6", bars, 32'h0001807F);

        run_frame(2'd1, 32'hFB05FF80);
        check("mag_bars", bars, 32'h0505017F);
        check("mag_fd", {31'b0, frame_done}, 32'h1);
        tick();

        // Peak-hold from a cleared work bank.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        run_frame(2'd2, 32'h00000340);
        check("pk_f1", bars, 32'h00000340);
        tick();
        run_frame(2'd2, 32'h00000000);
        check("pk_f2", bars, 32'h00000238);
        tick();
        run_frame(2'd2, 32'h00000000);
        check("pk_f3", bars, 32'h00000131);
        tick();
        run_frame(2'd2, 32'h80F00050);
        check("pk_f4", bars, 32'h7F100050);
        check("pk_ovr", {31'b0, overrun}, 32'h0);
        tick();
        run_frame(2'd3, 32'h80F00050);
        check("mode3_raw", bars, 32'h80F00050);
        tick();

        // Overrun: second rise sampled at E3.
        mode = 2'd0; samples = 32'h11223344; vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        samples = 32'hAAAAAAAA;
        tick();
        vsync = 1'b1;
        tick();
        check("ovr_set", {31'b0, overrun}, 32'h1);
        check("ovr_busy", {31'b0, busy}, 32'h1);
        vsync = 1'b0;
        tick();
        tick();
        check("ovr_bars", bars, 32'h11223344);
        check("ovr_fd", {31'b0, frame_done}, 32'h1);
        repeat (3) tick();
        check("ovr_idle", {31'b0, busy}, 32'h0);
        check("ovr_sticky", {31'b0, overrun}, 32'h1);

        // Freeze: rise is ignored entirely.
        freeze = 1'b1; samples = 32'hCAFEF00D; vsync = 1'b1;
        tick();
        check("frz_busy", {31'b0, busy}, 32'h0);
        vsync = 1'b0;
        fd_seen = 1'b0; busy_seen = 1'b0;
        repeat (6) begin
            tick();
            fd_seen   |= frame_done;
            busy_seen |= busy;
        end
        check("frz_fd", {31'b0, fd_seen}, 32'h0);
        check("frz_busy_any", {31'b0, busy_seen}, 32'h0);
        check("frz_bars", bars, 32'h11223344);
        freeze = 1'b0;

        // Reset mid-UPDATE, then vsync held high across reset release.
        mode = 2'd0; samples = 32'h55555555; vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mr_bars", bars, 32'h0);
        check("mr_fd", {31'b0, frame_done}, 32'h0);
        check("mr_busy", {31'b0, busy}, 32'h0);
        check("mr_ovr", {31'b0, overrun}, 32'h0);
        vsync = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        fd_seen = 1'b0; busy_seen = 1'b0;
        repeat (8) begin
            tick();
            fd_seen   |= frame_done;
            busy_seen |= busy;
        end
        check("hi_rel_busy", {31'b0, busy_seen}, 32'h0);
        check("hi_rel_fd", {31'b0, fd_seen}, 32'h0);
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        check("rearm_busy", {31'b0, busy}, 32'h1);
        vsync = 1'b0;
        repeat (5) tick();
        check("rearm_bars", bars, 32'h55555555);
        check("rearm_fd", {31'b0, frame_done}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
